// File: rtl/alu_pkg.sv
// Shared ALU control encodings, used by the ALU and by the control decoder.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND      = 3'b000,
    ALU_OR       = 3'b001,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b110,
    ALU_SLT      = 3'b111
  } alu_op_e;

  localparam int ALU_CTRL_W = 3;

  // Control[2] selects subtraction in the shared adder (SUBTRACT and SLT).
  function automatic logic is_sub(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl[2];
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit ripple adder with optional B inversion and carry-in, used for ADD/SUB/SLT.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign sum[gi]      = a[gi] ^ b_eff[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
  end

  assign cout = carry[WIDTH];
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/alu.sv
// Registered MIPS-style ALU: AND, OR, ADD, SUBTRACT, signed SLT with a Zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALU_CTRL_W-1:0] Control,
  input  logic [WIDTH-1:0]      SrcA,
  input  logic [WIDTH-1:0]      SrcB,
  output logic [WIDTH-1:0]      Result,
  output logic                  Zero
);

  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             addsub_cout_unused;
  logic             lt;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] result_reg;
  logic             zero_next;
  logic             zero_reg;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (SrcA),
    .b    (SrcB),
    .sub  (is_sub(Control)),
    .sum  (sum),
    .cout (addsub_cout_unused),
    .ovf  (ovf)
  );

  // Sign of the difference, corrected when the subtraction overflowed.
  assign lt = sum[WIDTH-1] ^ ovf;

  always_comb begin
    result_next = '0;
    case (Control)
      ALU_AND:      result_next = SrcA & SrcB;
      ALU_OR:       result_next = SrcA | SrcB;
      ALU_ADD:      result_next = sum;
      ALU_SUBTRACT: result_next = sum;
      ALU_SLT:      result_next = {{(WIDTH-1){1'b0}}, lt};
      default:      result_next = '0;
    endcase
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

  assign Result = result_reg;
  assign Zero   = zero_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized ops against a behavioural model.
module tb_alu;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [2:0]       Control;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Result;
  logic             Zero;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .Control (Control),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Result  (Result),
    .Zero    (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic logic [WIDTH-1:0] model(input logic [2:0] ctl,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (ctl)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive one transaction, clock it, and check the registered outputs one edge later.
  task automatic do_op(input string tag, input logic rst, input logic [2:0] ctl,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] exp_r;
    reset   = rst;
    Control = ctl;
    SrcA    = a;
    SrcB    = b;
    exp_r   = rst ? '0 : model(ctl, a, b);
    @(posedge clk);
    #1;
    $display("op %s rst=%0b ctl=%03b a=0x%02h b=0x%02h -> Result=0x%02h Zero=%0b (exp 0x%02h/%0b)",
             tag, rst, ctl, a, b, Result, Zero, exp_r, (exp_r == '0));
    check_value({tag, ".result"}, 32'(Result), 32'(exp_r));
    check_value({tag, ".zero"}, 32'(Zero), 32'(exp_r == '0));
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    reset = 1'b1; Control = 3'b010; SrcA = '0; SrcB = '0;
    @(negedge clk);

    do_op("reset",     1'b1, 3'b010, 8'h55, 8'h22);
    do_op("add3p4",    1'b0, 3'b010, 8'h03, 8'h04);
    do_op("add_wrap1", 1'b0, 3'b010, 8'hF0, 8'h20);
    do_op("add_wrap2", 1'b0, 3'b010, 8'hFF, 8'h01);
    do_op("sub_eq",    1'b0, 3'b110, 8'd123, 8'd123);
    do_op("sub_neg",   1'b0, 3'b110, 8'h05, 8'h09);
    do_op("and",       1'b0, 3'b000, 8'hCA, 8'h5F);
    do_op("or",        1'b0, 3'b001, 8'hCA, 8'h5F);
    do_op("slt_80_7f", 1'b0, 3'b111, 8'h80, 8'h7F);
    do_op("slt_7f_80", 1'b0, 3'b111, 8'h7F, 8'h80);
    do_op("slt_fe_ff", 1'b0, 3'b111, 8'hFE, 8'hFF);
    do_op("slt_eq",    1'b0, 3'b111, 8'h05, 8'h05);
    do_op("rsv011",    1'b0, 3'b011, 8'hFF, 8'hFF);
    do_op("rsv100",    1'b0, 3'b100, 8'h12, 8'h34);
    do_op("rsv101",    1'b0, 3'b101, 8'h81, 8'h7E);

    // Back-to-back sequence ending in a reserved code, then reset mid-stream.
    do_op("b2b_add",   1'b0, 3'b010, 8'h10, 8'h22);
    do_op("b2b_sub",   1'b0, 3'b110, 8'h10, 8'h22);
    do_op("b2b_and",   1'b0, 3'b000, 8'hF3, 8'h3C);
    do_op("b2b_or",    1'b0, 3'b001, 8'h03, 8'h30);
    do_op("b2b_slt",   1'b0, 3'b111, 8'h90, 8'h10);
    do_op("b2b_rsv",   1'b0, 3'b011, 8'h01, 8'h02);
    do_op("mid_rst",   1'b1, 3'b001, 8'hAA, 8'h55);
    do_op("post_rst",  1'b0, 3'b001, 8'hAA, 8'h55);

    for (int i = 0; i < 300; i++) begin
      logic rst;
      rst = ($urandom_range(0, 19) == 0);
      do_op("rand", rst, ops[$urandom_range(0, 7)],
            WIDTH'($urandom), WIDTH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
